// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the P7 pipeline sequencer: MDU state
// encodings, MDU latency defaults and the bundle of stall/flush controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic pc_en;
    logic fd_stall;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic mw_flush;
  } ctrl_t;

  // Free-running pipeline: PC advances, no register held or bubbled.
  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c          = '0;
    c.pc_en    = 1'b1;
    return c;
  endfunction

  // Bus wait freezes PC..EM and bubbles MW so W does not retire twice.
  function automatic ctrl_t ctrl_mem_wait();
    ctrl_t c;
    c          = '0;
    c.fd_stall = 1'b1;
    c.de_stall = 1'b1;
    c.em_stall = 1'b1;
    c.mw_flush = 1'b1;
    return c;
  endfunction

  // Decode stall: hold PC/FD, bubble into DE, let E/M/W drain.
  function automatic ctrl_t ctrl_d_stall();
    ctrl_t c;
    c          = '0;
    c.fd_stall = 1'b1;
    c.de_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_busy_tracker.sv
// MDU occupancy tracker: loads a latency countdown on an accepted
// mult/div start and reports busy until the count drains to zero.
module md_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A start always wins over the running countdown (reload semantics).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (go) begin
      state_d = is_div ? MD_DIV : MD_MULT;
      count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
      if (count_q == CNT_W'(1)) state_d = MD_IDLE;
    end else begin
      state_d = MD_IDLE;
    end
  end

  always_comb begin
    busy  = ~reset & ((count_q != '0) | go);
    count = count_q;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// P7 pipeline sequencer: prioritises exception, bus wait and decode
// hazards into PC/FD/DE/EM/MW controls and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             D_hazard_stall,
  input  logic             D_md_use,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  input  logic             M_mem_wait,
  output logic             PC_en,
  output logic             FD_stall,
  output logic             DE_stall,
  output logic             DE_flush,
  output logic             EM_stall,
  output logic             MW_flush,
  output logic             MD_busy,
  output logic [CNT_W-1:0] MD_count,
  output logic [31:0]      stall_count
);

  logic        md_go;
  logic        md_busy_int;
  logic        stall_d;
  ctrl_t       ctrl;
  logic [31:0] stall_cnt_q;

  // E is frozen under bus wait, so the start is taken only once it moves.
  assign md_go = E_md_start & ~req & ~M_mem_wait & ~reset;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .go     (md_go),
    .is_div (E_md_is_div),
    .busy   (md_busy_int),
    .count  (MD_count)
  );

  assign stall_d = D_hazard_stall | (D_md_use & md_busy_int);

  always_comb begin
    ctrl = ctrl_run();
    if (reset || req)    ctrl = ctrl_run();
    else if (M_mem_wait) ctrl = ctrl_mem_wait();
    else if (stall_d)    ctrl = ctrl_d_stall();
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!ctrl.pc_en && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    PC_en       = ctrl.pc_en;
    FD_stall    = ctrl.fd_stall;
    DE_stall    = ctrl.de_stall;
    DE_flush    = ctrl.de_flush;
    EM_stall    = ctrl.em_stall;
    MW_flush    = ctrl.mw_flush;
    MD_busy     = md_busy_int;
    stall_count = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req, hz, mduse, estart, isdiv, mwait;
  logic PC_en, FD_stall, DE_stall, DE_flush, EM_stall, MW_flush, MD_busy;
  logic [3:0]  MD_count;
  logic [31:0] stall_count;

  pipe_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .D_hazard_stall (hz),
    .D_md_use       (mduse),
    .E_md_start     (estart),
    .E_md_is_div    (isdiv),
    .M_mem_wait     (mwait),
    .PC_en          (PC_en),
    .FD_stall       (FD_stall),
    .DE_stall       (DE_stall),
    .DE_flush       (DE_flush),
    .EM_stall       (EM_stall),
    .MW_flush       (MW_flush),
    .MD_busy        (MD_busy),
    .MD_count       (MD_count),
    .stall_count    (stall_count)
  );

  int tests = 0;
  int fails = 0;

  // Model state: remaining MDU cycles and stalled-cycle tally.
  int          m_cnt = 0;
  logic [31:0] m_sc  = '0;
  logic        m_go, m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic q, input logic h, input logic u,
                        input logic s, input logic d, input logic w);
    reset = r; req = q; hz = h; mduse = u; estart = s; isdiv = d; mwait = w;
  endtask

  // Sample at negedge and compare every output with the model.
  task automatic step();
    logic busy, pc, fds, des, def, ems, mwf;
    @(negedge clk);
    m_go = estart && !req && !mwait && !reset;
    busy = !reset && (m_cnt != 0 || m_go);
    {pc, fds, des, def, ems, mwf} = 6'b100000;
    if (reset || req) ;
    else if (mwait) {pc, fds, des, def, ems, mwf} = 6'b011011;
    else if (hz || (mduse && busy)) {pc, fds, des, def, ems, mwf} = 6'b010100;
    m_pc = pc;
    chk("PC_en",    PC_en,    pc);
    chk("FD_stall", FD_stall, fds);
    chk("DE_stall", DE_stall, des);
    chk("DE_flush", DE_flush, def);
    chk("EM_stall", EM_stall, ems);
    chk("MW_flush", MW_flush, mwf);
    chk("MD_busy",  MD_busy,  busy);
    chk("MD_count", MD_count, m_cnt);
    chk("stall_count", stall_count, m_sc);
  endtask

  task automatic tick();
    if (reset) begin
      m_cnt = 0;
      m_sc  = '0;
    end else begin
      if (m_go) m_cnt = isdiv ? DIV : MULT;
      else if (m_cnt > 0) m_cnt--;
      if (!m_pc && m_sc != 32'hFFFF_FFFF) m_sc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    step(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 1, 0, 1);
    @(posedge clk); #1;

    // Reset held with start and bus wait asserted
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 1, 0, 1);
      step();
      chk("rst_pc_en", PC_en, 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_md_count", MD_count, 0);
    chk("rst_stall_count", stall_count, 0);
    tick();

    // mult then mfhi in D
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0);
    step(); chk("mult_go_busy", MD_busy, 1); tick();
    for (int i = 1; i <= 6; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 0);
      step();
      chk("mult_cnt", MD_count, 32'(6 - i));
      chk("mult_pc_en", PC_en, (i == 6) ? 1 : 0);
      chk("mult_de_flush", DE_flush, (i == 6) ? 0 : 1);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step(); chk("mult_stall_count", stall_count, 5); tick();

    // div start held across bus wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 1);
      step();
      chk("divw_em_stall", EM_stall, 1);
      chk("divw_mw_flush", MW_flush, 1);
      chk("divw_no_load", MD_count, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 1, 0);
    step(); chk("div_cnt_c3", MD_count, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step(); chk("div_cnt_c4", MD_count, 10); tick();
    step(); chk("div_cnt_c5", MD_count, 9); tick();
    step(); tick();
    // req mid-div at count 7
    set_in(0, 1, 1, 1, 0, 0, 0);
    step();
    chk("reqdiv_cnt", MD_count, 7);
    chk("reqdiv_pc_en", PC_en, 1);
    chk("reqdiv_fd_stall", FD_stall, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 6; i >= 0; i--) begin
      step(); chk("reqdiv_drain", MD_count, 32'(i)); tick();
    end

    // req with start and hazard together
    do_reset();
    set_in(0, 1, 1, 0, 1, 0, 0);
    step(); chk("req_pc_en", PC_en, 1); chk("req_de_flush", DE_flush, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step(); chk("req_no_load", MD_count, 0); tick();

    // hazard and bus wait together: bus wait wins
    set_in(0, 0, 1, 0, 0, 0, 1);
    step(); chk("hzw_em_stall", EM_stall, 1); chk("hzw_de_flush", DE_flush, 0); tick();

    // stall_count saturation via preload
    set_in(0, 0, 0, 0, 0, 0, 1);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFE;
    step(); chk("sat_preload", stall_count, 32'hFFFF_FFFE); tick();
    step(); chk("sat_max", stall_count, 32'hFFFF_FFFF); tick();
    step(); chk("sat_hold", stall_count, 32'hFFFF_FFFF); tick();

    // Randomized traffic; starts only offered while the MDU is idle
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             (m_cnt == 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 4) == 0));
      step();
      chk("no_reload", {31'b0, m_go && (MD_count != 0)}, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
